// File: rtl/sign_narrow.sv
// sign_narrow: narrows 32-bit two's-complement values to 17-bit signed
// immediates with wrap or saturate on overflow. A valid/ready handshake with
// a 2-entry skid buffer sits in front of the output, and a saturating counter
// tracks how many accepted values overflowed.
module sign_narrow #(
  parameter int unsigned IN_W  = 32,
  parameter int unsigned OUT_W = 17,
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in,
  input  logic             sat_en,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out,
  output logic             ovf,
  output logic [CNT_W-1:0] ovf_count,
  input  logic             clr_count
);

  // Bits that must all match the sign bit for a value to fit in OUT_W bits.
  localparam int unsigned HI_W = IN_W - OUT_W + 1;

  localparam logic [OUT_W-1:0] SAT_MAX = {1'b0, {(OUT_W-1){1'b1}}};
  localparam logic [OUT_W-1:0] SAT_MIN = {1'b1, {(OUT_W-1){1'b0}}};
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  typedef enum logic [1:0] {
    EMPTY,
    ONE,
    TWO
  } state_t;

  state_t           state;
  state_t           state_nxt;

  logic [HI_W-1:0]  hi;
  logic             fits;
  logic [OUT_W-1:0] res_data;
  logic             res_ovf;

  logic             accept;
  logic             produce;
  logic             load_main;
  logic             main_from_skid;
  logic             load_skid;

  logic [OUT_W-1:0] skid_data;
  logic             skid_ovf;

  assign hi      = in[IN_W-1:OUT_W-1];
  assign accept  = in_valid && in_ready;
  assign produce = out_valid && out_ready;

  // Fit detection and wrap/saturate selection on the incoming value.
  always_comb begin
    fits     = (hi == '0) || (hi == '1);
    res_data = in[OUT_W-1:0];
    res_ovf  = !fits;
    if (!fits && sat_en) begin
      res_data = in[IN_W-1] ? SAT_MIN : SAT_MAX;
    end
  end

  // Buffer next state and data-path load controls.
  always_comb begin
    state_nxt      = state;
    load_main      = 1'b0;
    main_from_skid = 1'b0;
    load_skid      = 1'b0;
    case (state)
      EMPTY: begin
        if (accept) begin
          load_main = 1'b1;
          state_nxt = ONE;
        end
      end
      ONE: begin
        if (accept && produce) begin
          load_main = 1'b1;
        end else if (accept) begin
          load_skid = 1'b1;
          state_nxt = TWO;
        end else if (produce) begin
          state_nxt = EMPTY;
        end
      end
      TWO: begin
        if (produce) begin
          main_from_skid = 1'b1;
          state_nxt      = ONE;
        end
      end
      default: state_nxt = EMPTY;
    endcase
  end

  // State register; handshake flags are registered from the next state so
  // in_ready never depends combinationally on out_ready.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= EMPTY;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
    end else begin
      state     <= state_nxt;
      in_ready  <= (state_nxt != TWO);
      out_valid <= (state_nxt != EMPTY);
    end
  end

  // Main (output) and skid result registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out       <= '0;
      ovf       <= 1'b0;
      skid_data <= '0;
      skid_ovf  <= 1'b0;
    end else begin
      if (load_main) begin
        out <= res_data;
        ovf <= res_ovf;
      end else if (main_from_skid) begin
        out <= skid_data;
        ovf <= skid_ovf;
      end
      if (load_skid) begin
        skid_data <= res_data;
        skid_ovf  <= res_ovf;
      end
    end
  end

  // Saturating overflow counter; clear has priority over increment.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ovf_count <= '0;
    end else if (clr_count) begin
      ovf_count <= '0;
    end else if (accept && res_ovf && (ovf_count != CNT_MAX)) begin
      ovf_count <= ovf_count + CNT_W'(1);
    end
  end

endmodule
